// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter.
//   uart_state_e    : transmit FSM states
//   UART_START_BIT  : line level of the start bit
//   UART_STOP_BIT   : line level of the stop bit (also the idle level)
//   UART_DATA_BITS  : data bits per frame
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;
  localparam int   UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_byte_fifo.sv
// Small synchronous FIFO with show-ahead read data.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset (pointers and level only)
//   push        : write push_data (ignored while full)
//   push_data   : entry to write
//   pop         : discard the head entry (ignored while empty)
//   pop_data    : current head entry, valid whenever empty is low
//   full, empty : occupancy flags derived from the registered level
//   level       : number of entries held
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter.
// Ports:
//   clk, resetn : system clock, asynchronous active-low reset
//   in_data     : byte to transmit
//   in_valid    : in_data valid; transfer on a rising edge with in_ready
//   in_ready    : FIFO has room (from the registered level only)
//   ser_tx      : registered serial output, idles high
//   busy        : registered; frame in flight or bytes queued
//   fifo_level  : bytes queued, excluding the byte in the shifter
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 106,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          ser_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int                 DIV_W    = $clog2(CLK_DIV);
  localparam int                 LVL_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DIV_W-1:0]   DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [2:0]         LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_state_e       state, state_nx;
  logic [DIV_W-1:0]  div_cnt, div_nx;
  logic [2:0]        bit_cnt, bit_nx;
  logic [7:0]        shift, shift_nx;
  logic              ser_tx_nx;
  logic              busy_nx;
  logic              push;
  logic              pop;
  logic [7:0]        fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;

  uart_byte_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_comb begin
    state_nx = state;
    div_nx   = div_cnt;
    bit_nx   = bit_cnt;
    shift_nx = shift;
    pop      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          shift_nx = fifo_dout;
          div_nx   = DIV_LOAD;
          state_nx = ST_START;
        end
      end
      ST_START: begin
        if (div_cnt == '0) begin
          div_nx   = DIV_LOAD;
          bit_nx   = '0;
          state_nx = ST_DATA;
        end else begin
          div_nx = div_cnt - DIV_W'(1);
        end
      end
      ST_DATA: begin
        if (div_cnt == '0) begin
          div_nx = DIV_LOAD;
          if (bit_cnt == LAST_BIT) begin
            state_nx = ST_STOP;
          end else begin
            bit_nx   = bit_cnt + 3'd1;
            shift_nx = shift >> 1;
          end
        end else begin
          div_nx = div_cnt - DIV_W'(1);
        end
      end
      ST_STOP: begin
        if (div_cnt == '0) begin
          // Chain straight into the next start bit when a byte is waiting.
          if (!fifo_empty) begin
            pop      = 1'b1;
            shift_nx = fifo_dout;
            div_nx   = DIV_LOAD;
            state_nx = ST_START;
          end else begin
            state_nx = ST_IDLE;
          end
        end else begin
          div_nx = div_cnt - DIV_W'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Line level and busy are computed from next-state values so both
  // registered outputs change on the same edge as the FSM.
  always_comb begin
    case (state_nx)
      ST_START: ser_tx_nx = UART_START_BIT;
      ST_DATA:  ser_tx_nx = shift_nx[0];
      default:  ser_tx_nx = UART_STOP_BIT;
    endcase
    // Queue is non-empty after this edge iff a push lands or more is held than popped.
    busy_nx = (state_nx != ST_IDLE) || push || (fifo_level > LVL_W'(pop));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      ser_tx  <= UART_STOP_BIT;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      div_cnt <= div_nx;
      bit_cnt <= bit_nx;
      ser_tx  <= ser_tx_nx;
      busy    <= busy_nx;
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_nx;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int DEPTH = 4;
  localparam int DIV0  = 106;
  localparam int DIV1  = 2;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] in_data0 = 8'h00, in_data1 = 8'h00;
  logic       in_valid0 = 1'b0, in_valid1 = 1'b0;
  logic       in_ready0, in_ready1, ser_tx0, ser_tx1, busy0, busy1;
  logic [2:0] fifo_level0, fifo_level1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [9:0] upat = 10'b1010101010;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(.CLK_DIV(DIV0), .FIFO_DEPTH(DEPTH)) dut0 (
    .clk(clk), .resetn(resetn), .in_data(in_data0), .in_valid(in_valid0),
    .in_ready(in_ready0), .ser_tx(ser_tx0), .busy(busy0), .fifo_level(fifo_level0)
  );

  uart_tx_fifo #(.CLK_DIV(DIV1), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .resetn(resetn), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .ser_tx(ser_tx1), .busy(busy1), .fifo_level(fifo_level1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: a byte queue plus the position inside the current frame.
  logic [7:0] mq [2][8];
  int         mcnt [2];
  int         mt [2];
  bit         mact [2];
  logic [7:0] mbyte [2];

  function automatic int div_of(input int k);
    return (k == 0) ? DIV0 : DIV1;
  endfunction

  task automatic model_step(input int k, input logic v, input logic [7:0] d);
    bit acc;
    int had;
    acc = v && (mcnt[k] < DEPTH);
    had = mcnt[k];
    if (mact[k]) begin
      mt[k]++;
      if (mt[k] >= 10 * div_of(k)) mact[k] = 1'b0;
    end
    if (!mact[k] && had > 0) begin
      mbyte[k] = mq[k][0];
      for (int j = 0; j < 7; j++) mq[k][j] = mq[k][j+1];
      mcnt[k]--;
      mact[k] = 1'b1;
      mt[k] = 0;
    end
    if (acc) begin
      mq[k][mcnt[k]] = d;
      mcnt[k]++;
    end
  endtask

  function automatic logic exp_tx(input int k);
    int b;
    if (!mact[k]) return 1'b1;
    b = mt[k] / div_of(k);
    if (b == 0) return 1'b0;
    if (b <= 8) return mbyte[k][b-1];
    return 1'b1;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < 2; k++) begin
        mcnt[k] = 0;
        mt[k] = 0;
        mact[k] = 1'b0;
      end
    end else begin
      model_step(0, in_valid0, in_data0);
      model_step(1, in_valid1, in_data1);
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      chk("ser_tx0",   ser_tx0,     exp_tx(0));
      chk("busy0",     busy0,       mact[0] || mcnt[0] != 0);
      chk("level0",    fifo_level0, mcnt[0]);
      chk("in_ready0", in_ready0,   mcnt[0] < DEPTH);
      chk("ser_tx1",   ser_tx1,     exp_tx(1));
      chk("busy1",     busy1,       mact[1] || mcnt[1] != 0);
      chk("level1",    fifo_level1, mcnt[1]);
      chk("in_ready1", in_ready1,   mcnt[1] < DEPTH);
    end
  end

  // Serial monitor on dut0: samples mid-bit and logs decoded bytes.
  logic [7:0] rx_log [16];
  int         rx_n = 0;

  initial begin : monitor
    logic [7:0] b;
    forever begin
      @(negedge ser_tx0);
      repeat (DIV0 / 2) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
        repeat (DIV0) @(posedge clk);
        #1;
        b[i] = ser_tx0;
      end
      repeat (DIV0) @(posedge clk);
      #1;
      if (rx_n < 16) begin
        rx_log[rx_n] = b;
        rx_n++;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  task automatic at_cycle(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic send0(input logic [7:0] d);
    in_valid0 = 1'b1;
    in_data0  = d;
    @(negedge clk);
    in_valid0 = 1'b0;
  endtask

  initial begin : stim
    int t0;
    int acc_cyc [7];
    int budget;
    bit done;
    bit bad;
    logic [7:0] hi [4];
    logic       e;

    hi[0] = 8'h48; hi[1] = 8'h69; hi[2] = 8'h21; hi[3] = 8'h0A;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ser_tx",   ser_tx0,     1);
    chk("rst_in_ready", in_ready0,   1);
    chk("rst_busy",     busy0,       0);
    chk("rst_level",    fifo_level0, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Single byte 0x55
    rx_n = 0;
    t0 = cyc + 1;
    send0(8'h55);
    at_cycle(t0 + 1);
    chk("u_fall", ser_tx0, 0);
    for (int i = 0; i < 10; i++) begin
      at_cycle(t0 + 1 + DIV0 * i + DIV0 / 2);
      chk("u_bit", ser_tx0, upat[i]);
    end
    at_cycle(t0 + 1060);
    chk("u_busy_1060", busy0, 1);
    at_cycle(t0 + 1061);
    chk("u_busy_1061", busy0, 0);
    at_cycle(t0 + 1100);
    chk("u_rx_n", rx_n, 1);
    chk("u_rx_byte", rx_log[0], 8'h55);

    // Back-to-back "Hi!\n"
    rx_n = 0;
    t0 = cyc + 1;
    for (int i = 0; i < 4; i++) send0(hi[i]);
    at_cycle(t0 + 1060);
    chk("hi_stop1", ser_tx0, 1);
    at_cycle(t0 + 1061);
    chk("hi_start2", ser_tx0, 0);
    at_cycle(t0 + 4240);
    chk("hi_busy_4240", busy0, 1);
    at_cycle(t0 + 4241);
    chk("hi_busy_4241", busy0, 0);
    at_cycle(t0 + 4300);
    chk("hi_rx_n", rx_n, 4);
    for (int i = 0; i < 4; i++) chk("hi_rx_byte", rx_log[i], hi[i]);

    // Backpressure: seven incrementing bytes with in_valid held
    rx_n = 0;
    t0 = cyc + 1;
    for (int i = 0; i < 7; i++) begin
      if (i == 5) begin
        chk("bp_level_full", fifo_level0, 4);
        chk("bp_ready_low",  in_ready0,   0);
      end
      in_valid0 = 1'b1;
      in_data0  = 8'(i);
      budget = 0;
      done = 1'b0;
      acc_cyc[i] = -1;
      while (!done && budget < 3000) begin
        done = in_ready0;
        @(negedge clk);
        budget++;
        if (done) acc_cyc[i] = cyc;
      end
      chk("bp_accept", done, 1);
    end
    in_valid0 = 1'b0;
    for (int i = 0; i < 5; i++) chk("bp_acc_cycle", acc_cyc[i], t0 + i);
    chk("bp_acc6_cycle", acc_cyc[5], t0 + 1062);
    chk("bp_acc7_cycle", acc_cyc[6], t0 + 2122);
    at_cycle(t0 + 7480);
    chk("bp_rx_n", rx_n, 7);
    for (int i = 0; i < 7; i++) chk("bp_rx_byte", rx_log[i], 8'(i));
    chk("bp_idle_busy", busy0, 0);

    // Minimum divider on dut1: 0xFF then 0x00
    t0 = cyc + 1;
    in_valid1 = 1'b1;
    in_data1  = 8'hFF;
    @(negedge clk);
    in_data1  = 8'h00;
    @(negedge clk);
    in_valid1 = 1'b0;
    for (int c = 1; c <= 41; c++) begin
      at_cycle(t0 + c);
      e = (c <= 2) ? 1'b0 : (c <= 20) ? 1'b1 : (c <= 38) ? 1'b0 : 1'b1;
      chk("div2_tx", ser_tx1, e);
      if (c >= 40) chk("div2_busy", busy1, (c == 40));
    end

    // Idle handshake with toggling data
    bad = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      in_data0 = 8'($urandom);
      in_data1 = ~in_data0;
      @(negedge clk);
      if (ser_tx0 !== 1'b1 || busy0 !== 1'b0 || fifo_level0 !== 3'd0 ||
          ser_tx1 !== 1'b1 || busy1 !== 1'b0 || fifo_level1 !== 3'd0) bad = 1'b1;
    end
    chk("idle_quiet", bad, 0);

    // Reset during data bit 3 of 0xA5 with two bytes queued
    t0 = cyc + 1;
    send0(8'hA5);
    send0(8'h11);
    send0(8'h22);
    at_cycle(t0 + 1 + 4 * DIV0 + 50);
    chk("pre_rst_tx",    ser_tx0,     0);
    chk("pre_rst_level", fifo_level0, 2);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_mid_tx",    ser_tx0,     1);
    chk("rst_mid_level", fifo_level0, 0);
    chk("rst_mid_busy",  busy0,       0);
    chk("rst_mid_ready", in_ready0,   1);
    @(negedge clk);
    resetn = 1'b1;
    bad = 1'b0;
    repeat (700) begin
      @(negedge clk);
      if (ser_tx0 !== 1'b1 || busy0 !== 1'b0) bad = 1'b1;
    end
    chk("post_rst_quiet", bad, 0);
    rx_n = 0;
    t0 = cyc + 1;
    send0(8'h3C);
    at_cycle(t0 + 1100);
    chk("post_rst_rx_n", rx_n, 1);
    chk("post_rst_byte", rx_log[0], 8'h3C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter for the PicoSoC/hx8kdemo serial path: accepts bytes over a valid/ready handshake, queues them in a small FIFO, and serialises them as 8N1 frames on `ser_tx`. It is the driving end of the serial line that the bench serial monitor samples. In the SoC it feeds the board `ser_tx` pin. On the bench it also drives `ser_rx` of the DUT for console stimulus.

## Interface
- `CLK_DIV`, 106: clock cycles per bit; legal range 2..65535; a half-bit is `CLK_DIV/2` (53 at default).
- `FIFO_DEPTH`, 4: byte FIFO entries; power of two, ≥2.
- `clk`  in  1  system clock.
- `resetn`  in  1  one clock; reset is asynchronous and active-low.
- `in_data`  in  8  byte to transmit.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  FIFO can accept; a transfer occurs on a rising `clk` edge with `in_valid && in_ready`.
- `ser_tx`  out  1  serial line; idles high.
- `busy`  out  1  frame in flight or FIFO non-empty.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  bytes queued, excluding the byte in the shifter.

## Operation
- Reset values: `ser_tx`=1, `in_ready`=1, `busy`=0, `fifo_level`=0. FIFO pointers, divider, bit counter and state are cleared.
- Frame format: start bit 0, then data bits LSB first, then stop bit 1. Each bit lasts exactly `CLK_DIV` cycles. A frame is 10·`CLK_DIV` cycles.
- FSM states:
  - IDLE: `ser_tx`=1. If the FIFO is non-empty, pop into the shift register, load the divider and go to START.
  - START: `ser_tx`=0 for `CLK_DIV` cycles, then go to DATA with bit count 0.
  - DATA: `ser_tx`=shift[0] for `CLK_DIV` cycles per bit, then shift right. After bit 7, go to STOP.
  - STOP: `ser_tx`=1 for `CLK_DIV` cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Divider: down-counter from `CLK_DIV-1`. A bit boundary occurs when it reads 0. Width is $clog2(CLK_DIV).
- `ser_tx` is a registered output. No combinational path exists from the inputs to `ser_tx`.
- `in_ready` = (`fifo_level` < `FIFO_DEPTH`), derived from registered count only. There is no same-cycle bypass when full, even if a pop occurs that cycle.
- Simultaneous push and pop with the FIFO non-full and non-empty: the level is unchanged and data order is preserved.
- A push while full cannot occur (`in_ready`=0). `in_data` is ignored when `in_valid`=0.
- `busy` = (state≠IDLE) || (`fifo_level`≠0). It is registered.
- Reset asserted mid-frame: `ser_tx` goes high asynchronously. The partial frame and all queued bytes are discarded.

## Timing
- Latency with the block idle and the FIFO empty: push accepted at edge N. The FIFO is non-empty at N. Pop occurs at edge N+1, and `ser_tx` falls after edge N+1.
- Stop bit ends at N+1+10·`CLK_DIV`. `busy` falls on the same edge if nothing is queued.
- Back-to-back frames: the next start bit begins on the edge that ends the previous stop bit.
- Throughput: 1 byte per 10·`CLK_DIV` cycles, sustained.

## Structure
- Package `uart_pkg`:
  - state enum (IDLE, START, DATA, STOP);
  - constants `UART_START_BIT`=0, `UART_STOP_BIT`=1, `UART_DATA_BITS`=8.
- Sub-module `uart_byte_fifo`: synchronous FIFO parameterised by width and depth.
  - Ports: push/pop/data, with full, empty and level outputs.
  - Same `clk`/`resetn` as the parent.
- The top level holds the FSM, divider, bit counter and shift register.

## Test plan
- Single byte, CLK_DIV=106: push 0x55 at cycle 0.
  - `ser_tx` falls at cycle 1.
  - Serial sampling at 53 cycles into each bit reads 0,1,0,1,0,1,0,1,0,1 (start, data LSB first, stop), which the serial monitor decodes as 'U'.
  - `busy` falls at cycle 1061.
- Back-to-back: push "Hi!\n" (0x48,0x69,0x21,0x0A) in consecutive cycles.
  - Four contiguous frames with no high gap between stop and start bits.
  - Total duration 4240 cycles; the monitor prints "Hi!\n".
- Backpressure, FIFO_DEPTH=4: hold `in_valid` with 7 incrementing bytes 0x00..0x06.
  - 5 bytes are accepted (1 in the shifter, 4 queued), then `in_ready`=0 and `fifo_level`=4.
  - The 6th byte is accepted on the edge after the first frame's stop bit ends.
  - All 7 bytes are transmitted in order.
- Reset mid-frame: assert `resetn`=0 during data bit 3 of 0xA5 with 2 bytes queued.
  - `ser_tx`=1 immediately; `fifo_level`=0, `busy`=0, `in_ready`=1.
  - After release, no frame is emitted until a new push.
- Minimum divider, CLK_DIV=2: push 0xFF, then 0x00.
  - Each bit lasts 2 cycles; the frames are 0,1×8,1 and then 0,0×8,1.
  - Total duration 40 cycles.
- Handshake idle: `in_valid`=0 with `in_data` toggling for 1000 cycles.
  - `ser_tx` stays 1, `busy` stays 0 and `fifo_level` stays 0.
